// File: rtl/pair_shift_pkg.sv
// Shared types for the paired-register shift engine and the divider datapaths.
package pair_shift_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0,
    SH_LSR = 2'd1,
    SH_ASR = 2'd2,
    SH_ROL = 2'd3
  } shift_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage : pair_shift_pkg

// File: rtl/pair_shift_engine_shift_step.sv
// One single-bit shift of a PAIR_W-bit value; purely combinational so the
// divider datapath can reuse it outside the engine.
module shift_step
  import pair_shift_pkg::*;
#(
  parameter int PAIR_W = 16
) (
  input  logic [PAIR_W-1:0] pair,
  input  shift_mode_e       mode,
  input  logic              sin,
  output logic [PAIR_W-1:0] next_pair,
  output logic              out_bit
);

  // NOTE: every output gets a default first so no path through the case leaves one unassigned (no latch).
  always_comb begin
    next_pair = pair;
    out_bit   = 1'b0;
    unique case (mode)
      SH_LSL: begin
        next_pair = {pair[PAIR_W-2:0], sin};
        out_bit   = pair[PAIR_W-1];
      end
      SH_LSR: begin
        next_pair = {sin, pair[PAIR_W-1:1]};
        out_bit   = pair[0];
      end
      SH_ASR: begin
        next_pair = {pair[PAIR_W-1], pair[PAIR_W-1:1]};
        out_bit   = pair[0];
      end
      SH_ROL: begin
        next_pair = {pair[PAIR_W-2:0], pair[PAIR_W-1]};
        out_bit   = pair[PAIR_W-1];
      end
      default: ;
    endcase
  end

endmodule : shift_step

// File: rtl/pair_shift_engine.sv
// Multi-cycle shifter over {hi, lo}: parallel load, then start/done handshake
// shifting one bit per clock; the last bit shifted out is kept in cout.
module pair_shift_engine
  import pair_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(2*WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [WIDTH-1:0] d_hi,
  input  logic [WIDTH-1:0] d_lo,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic             sin,
  output logic [WIDTH-1:0] q_hi,
  output logic [WIDTH-1:0] q_lo,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int PAIR_W = 2 * WIDTH;

  state_e            state_q, state_d;
  logic [AMT_W-1:0]  cnt_q;
  shift_mode_e       mode_q;
  logic [PAIR_W-1:0] pair_q;
  logic [PAIR_W-1:0] step_pair;
  logic              step_out;
  logic              cout_q;

  shift_step #(.PAIR_W(PAIR_W)) u_step (
    .pair      (pair_q),
    .mode      (mode_q),
    .sin       (sin),
    .next_pair (step_pair),
    .out_bit   (step_out)
  );

  // Load has priority over start in IDLE; the last shift is the one taken with cnt == 1.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!load_en && start)
          state_d = (amt == '0) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_q == AMT_W'(1))
          state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= SH_LSL;
      pair_q  <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_IDLE: begin
          if (load_en) begin
            pair_q <= {d_hi, d_lo};
          end else if (start) begin
            mode_q <= shift_mode_e'(mode);
            cnt_q  <= amt;
          end
        end
        ST_SHIFT: begin
          pair_q <= step_pair;
          cout_q <= step_out;
          cnt_q  <= cnt_q - AMT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Status outputs decode the state register only, so they stay registered.
  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
  assign q_hi = pair_q[PAIR_W-1:WIDTH];
  assign q_lo = pair_q[WIDTH-1:0];
  assign cout = cout_q;

endmodule : pair_shift_engine
